// File: rtl/correlator_pkg.sv
// Shared definitions for the correlator doinit bank.
//   ch_state_e   : per-channel FSM encoding (IDLE = flag low, ARMED = flag high)
//   NUM_CH_DEF   : default number of correlator channels
//   EPW_DEF      : default width of the hold-epoch count
//   TOW_DEF      : default width of the watchdog cycle count
//   EPOCH_MIN    : smallest epoch load; a programmed hold of 0 loads this instead
package correlator_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } ch_state_e;

  localparam int NUM_CH_DEF = 8;
  localparam int EPW_DEF    = 4;
  localparam int TOW_DEF    = 16;

  localparam int EPOCH_MIN  = 1;

endpackage

// File: rtl/channel_doinit_slice.sv
// One channel of the doinit bank: FSM, epoch counter, watchdog counter,
// watchdog enable, completion pulse and sticky timeout flag.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   doinit_pulse      : one-cycle set / restart request
//   intr_pulse        : one-cycle epoch pulse from the channel
//   hold_epochs       : epochs to survive, sampled on set (0 loads 1)
//   timeout_en        : watchdog enable, sampled on set
//   timeout_cycles    : watchdog load value, sampled on set
//   sts_clr           : clear of the sticky timeout flag
//   state             : registered FSM state (doinit == ARMED)
//   doinit_next       : next-cycle value of doinit, used for the bank busy register
//   done_pulse        : one-cycle pulse after the completing intr
//   timeout_flag      : sticky watchdog expiry flag
//
// All inputs are single-cycle level samples; there is no handshake. Priority
// per cycle: doinit_pulse > completing intr_pulse > watchdog expiry.
module channel_doinit_slice
  import correlator_pkg::*;
#(
  parameter int EPW = EPW_DEF,
  parameter int TOW = TOW_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           doinit_pulse,
  input  logic           intr_pulse,
  input  logic [EPW-1:0] hold_epochs,
  input  logic           timeout_en,
  input  logic [TOW-1:0] timeout_cycles,
  input  logic           sts_clr,
  output ch_state_e      state,
  output logic           doinit_next,
  output logic           done_pulse,
  output logic           timeout_flag
);

  logic [EPW-1:0] ep_cnt;
  logic [TOW-1:0] wd_cnt;
  logic           wd_en;
  logic [EPW-1:0] ep_load;
  logic           armed;
  logic           complete;
  logic           expire;

  // A programmed hold of zero would otherwise never complete.
  assign ep_load  = (hold_epochs == '0) ? EPW'(EPOCH_MIN) : hold_epochs;

  assign armed    = (state == ARMED);
  // A set in the same cycle masks both completion and expiry (restart).
  assign complete = armed && !doinit_pulse && intr_pulse && (ep_cnt == EPW'(1));
  assign expire   = armed && !doinit_pulse && !complete && wd_en && (wd_cnt == '0);

  assign doinit_next = doinit_pulse || (armed && !complete && !expire);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ep_cnt       <= '0;
      wd_cnt       <= '0;
      wd_en        <= 1'b0;
      done_pulse   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      done_pulse <= 1'b0;

      // Expiry wins over a same-cycle clear; a new set leaves the flag alone.
      if (expire) begin
        timeout_flag <= 1'b1;
      end else if (sts_clr) begin
        timeout_flag <= 1'b0;
      end

      if (doinit_pulse) begin
        state  <= ARMED;
        ep_cnt <= ep_load;
        wd_cnt <= timeout_cycles;
        wd_en  <= timeout_en;
      end else if (armed) begin
        if (complete) begin
          state      <= IDLE;
          done_pulse <= 1'b1;
        end else if (expire) begin
          state <= IDLE;
        end else begin
          // ep_cnt is >= 2 here whenever intr_pulse is high, and wd_cnt is
          // non-zero whenever wd_en is high, so neither counter can wrap.
          if (intr_pulse) begin
            ep_cnt <= ep_cnt - EPW'(1);
          end
          if (wd_en) begin
            wd_cnt <= wd_cnt - TOW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/channel_doinit_bank.sv
// Bank of per-channel doinit flags between the register file and the
// correlator channels.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   doinit_pulse    : per-channel set request from a register write
//   intr_pulse      : per-channel epoch/interrupt pulse
//   hold_epochs     : epochs a flag must survive (0 treated as 1), sampled on set
//   timeout_en      : watchdog enable, sampled per channel on set
//   timeout_cycles  : watchdog load value, sampled on set
//   sts_clr         : per-channel clear of the sticky timeout flag
//   doinit          : per-channel doinit flag
//   done_pulse      : per-channel one-cycle normal-completion pulse
//   timeout_flag    : per-channel sticky watchdog-expiry flag
//   busy            : registered OR of doinit, cycle-aligned with doinit
module channel_doinit_bank
  import correlator_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int EPW    = EPW_DEF,
  parameter int TOW    = TOW_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] doinit_pulse,
  input  logic [NUM_CH-1:0] intr_pulse,
  input  logic [EPW-1:0]    hold_epochs,
  input  logic              timeout_en,
  input  logic [TOW-1:0]    timeout_cycles,
  input  logic [NUM_CH-1:0] sts_clr,
  output logic [NUM_CH-1:0] doinit,
  output logic [NUM_CH-1:0] done_pulse,
  output logic [NUM_CH-1:0] timeout_flag,
  output logic              busy
);

  // Per-channel FSM state, kept visible here for debug and checker binding.
  ch_state_e         ch_state [NUM_CH];
  logic [NUM_CH-1:0] doinit_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    channel_doinit_slice #(
      .EPW (EPW),
      .TOW (TOW)
    ) u_slice (
      .clk            (clk),
      .reset_n        (reset_n),
      .doinit_pulse   (doinit_pulse[i]),
      .intr_pulse     (intr_pulse[i]),
      .hold_epochs    (hold_epochs),
      .timeout_en     (timeout_en),
      .timeout_cycles (timeout_cycles),
      .sts_clr        (sts_clr[i]),
      .state          (ch_state[i]),
      .doinit_next    (doinit_next[i]),
      .done_pulse     (done_pulse[i]),
      .timeout_flag   (timeout_flag[i])
    );

    assign doinit[i] = (ch_state[i] == ARMED);
  end

  // Built from the next-state vector so busy rises and falls with doinit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= |doinit_next;
    end
  end

endmodule

// File: tb/tb_channel_doinit_bank.sv
module tb_channel_doinit_bank;

  localparam int NUM_CH = 8;
  localparam int EPW    = 4;
  localparam int TOW    = 16;

  logic              clk;
  logic              reset_n;
  logic [NUM_CH-1:0] doinit_pulse;
  logic [NUM_CH-1:0] intr_pulse;
  logic [EPW-1:0]    hold_epochs;
  logic              timeout_en;
  logic [TOW-1:0]    timeout_cycles;
  logic [NUM_CH-1:0] sts_clr;
  logic [NUM_CH-1:0] doinit;
  logic [NUM_CH-1:0] done_pulse;
  logic [NUM_CH-1:0] timeout_flag;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  channel_doinit_bank #(
    .NUM_CH (NUM_CH),
    .EPW    (EPW),
    .TOW    (TOW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .doinit_pulse   (doinit_pulse),
    .intr_pulse     (intr_pulse),
    .hold_epochs    (hold_epochs),
    .timeout_en     (timeout_en),
    .timeout_cycles (timeout_cycles),
    .sts_clr        (sts_clr),
    .doinit         (doinit),
    .done_pulse     (done_pulse),
    .timeout_flag   (timeout_flag),
    .busy           (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock edge and settle 1 time unit past it; inputs driven
  // before the call are sampled on that edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    doinit_pulse = '0;
    intr_pulse   = '0;
    sts_clr      = '0;
  endtask

  task automatic arm(input logic [NUM_CH-1:0] ch, input logic [EPW-1:0] hold,
                     input logic ten, input logic [TOW-1:0] tcyc);
    doinit_pulse   = ch;
    hold_epochs    = hold;
    timeout_en     = ten;
    timeout_cycles = tcyc;
    cycle();
    doinit_pulse   = '0;
  endtask

  task automatic pulse_intr(input logic [NUM_CH-1:0] ch);
    intr_pulse = ch;
    cycle();
    intr_pulse = '0;
  endtask

  // Small reference model for the independence test.
  logic [NUM_CH-1:0] m_armed;
  logic [EPW-1:0]    m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_done;
  logic [NUM_CH-1:0] intr_pat [12];
  logic [NUM_CH-1:0] done_seen;

  initial begin
    reset_n        = 1'b0;
    hold_epochs    = '0;
    timeout_en     = 1'b0;
    timeout_cycles = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    cycle();

    // ---- reset state ----
    check_eq("rst_doinit", 32'(doinit), 32'h0);
    check_eq("rst_done", 32'(done_pulse), 32'h0);
    check_eq("rst_tflag", 32'(timeout_flag), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);

    // ---- basic hold=1 on channel 0 ----
    arm(8'h01, 4'd1, 1'b0, 16'd0);
    check_eq("t1_doinit_set", 32'(doinit), 32'h01);
    check_eq("t1_busy_set", 32'(busy), 32'h1);
    repeat (9) cycle();
    check_eq("t1_doinit_hold", 32'(doinit), 32'h01);
    pulse_intr(8'h01);
    check_eq("t1_doinit_clr", 32'(doinit), 32'h00);
    check_eq("t1_done", 32'(done_pulse), 32'h01);
    check_eq("t1_busy_clr", 32'(busy), 32'h0);
    cycle();
    check_eq("t1_done_one", 32'(done_pulse), 32'h00);

    // ---- multi-epoch on channel 2, idle intr ignored ----
    pulse_intr(8'h04);
    check_eq("t2_idle_intr_doinit", 32'(doinit), 32'h00);
    check_eq("t2_idle_intr_done", 32'(done_pulse), 32'h00);
    arm(8'h04, 4'd3, 1'b0, 16'd0);
    check_eq("t2_doinit_set", 32'(doinit), 32'h04);
    repeat (4) cycle();
    pulse_intr(8'h04);
    check_eq("t2_after_1", 32'(doinit), 32'h04);
    repeat (4) cycle();
    pulse_intr(8'h04);
    check_eq("t2_after_2", 32'(doinit), 32'h04);
    check_eq("t2_no_early_done", 32'(done_pulse), 32'h00);
    repeat (4) cycle();
    pulse_intr(8'h04);
    check_eq("t2_after_3", 32'(doinit), 32'h00);
    check_eq("t2_done", 32'(done_pulse), 32'h04);
    cycle();
    check_eq("t2_done_one", 32'(done_pulse), 32'h00);
    arm(8'h04, 4'd0, 1'b0, 16'd0);
    pulse_intr(8'h04);
    check_eq("t2_hold0_doinit", 32'(doinit), 32'h00);
    check_eq("t2_hold0_done", 32'(done_pulse), 32'h04);

    // ---- watchdog on channel 1, timeout_cycles=4 ----
    arm(8'h02, 4'd2, 1'b1, 16'd4);
    check_eq("t3_doinit_c1", 32'(doinit), 32'h02);
    repeat (4) cycle();
    check_eq("t3_doinit_c5", 32'(doinit), 32'h02);
    check_eq("t3_tflag_pre", 32'(timeout_flag), 32'h00);
    cycle();
    check_eq("t3_doinit_exp", 32'(doinit), 32'h00);
    check_eq("t3_tflag_exp", 32'(timeout_flag), 32'h02);
    check_eq("t3_no_done", 32'(done_pulse), 32'h00);
    check_eq("t3_busy_exp", 32'(busy), 32'h0);
    // New set does not clear the sticky flag; watchdog disabled stays armed.
    arm(8'h02, 4'd1, 1'b0, 16'd0);
    repeat (20) cycle();
    check_eq("t3_wd_off_doinit", 32'(doinit), 32'h02);
    check_eq("t3_tflag_kept", 32'(timeout_flag), 32'h02);
    sts_clr = 8'h02;
    cycle();
    sts_clr = '0;
    check_eq("t3_tflag_clr", 32'(timeout_flag), 32'h00);
    pulse_intr(8'h02);
    check_eq("t3_wd_off_done", 32'(done_pulse), 32'h02);
    // timeout_cycles=0 -> exactly one cycle of doinit
    arm(8'h08, 4'd1, 1'b1, 16'd0);
    check_eq("t3_tc0_c1", 32'(doinit), 32'h08);
    cycle();
    check_eq("t3_tc0_c2", 32'(doinit), 32'h00);
    check_eq("t3_tc0_tflag", 32'(timeout_flag), 32'h08);
    sts_clr = 8'h08;
    cycle();
    sts_clr = '0;
    check_eq("t3_tc0_clr", 32'(timeout_flag), 32'h00);

    // ---- collisions ----
    // set + completing intr: restart with hold=2
    arm(8'h01, 4'd1, 1'b0, 16'd0);
    doinit_pulse = 8'h01;
    hold_epochs  = 4'd2;
    intr_pulse   = 8'h01;
    cycle();
    idle_inputs();
    check_eq("t4a_stay_armed", 32'(doinit), 32'h01);
    check_eq("t4a_no_done", 32'(done_pulse), 32'h00);
    pulse_intr(8'h01);
    check_eq("t4a_reload_1", 32'(doinit), 32'h01);
    pulse_intr(8'h01);
    check_eq("t4a_reload_2", 32'(doinit), 32'h00);
    check_eq("t4a_done", 32'(done_pulse), 32'h01);
    // completing intr on the expiry cycle of channel 4
    arm(8'h10, 4'd1, 1'b1, 16'd2);
    repeat (2) cycle();
    pulse_intr(8'h10);
    check_eq("t4b_doinit", 32'(doinit), 32'h00);
    check_eq("t4b_done", 32'(done_pulse), 32'h10);
    check_eq("t4b_tflag", 32'(timeout_flag), 32'h00);
    // sts_clr on the expiry cycle of channel 5
    arm(8'h20, 4'd1, 1'b1, 16'd1);
    cycle();
    sts_clr = 8'h20;
    cycle();
    sts_clr = '0;
    check_eq("t4c_tflag_set_wins", 32'(timeout_flag), 32'h20);
    check_eq("t4c_doinit", 32'(doinit), 32'h00);
    sts_clr = 8'h20;
    cycle();
    sts_clr = '0;
    check_eq("t4c_tflag_clr", 32'(timeout_flag), 32'h00);

    // ---- independence: channel i holds for i+1 epochs ----
    intr_pat = '{8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'hFF,
                 8'h33, 8'hCC, 8'hFF, 8'h81, 8'hFF, 8'hFF};
    for (int i = 0; i < NUM_CH; i++) begin
      arm(NUM_CH'(1) << i, EPW'(i + 1), 1'b0, 16'd0);
      m_cnt[i] = EPW'(i + 1);
    end
    m_armed = '1;
    check_eq("t5_all_armed", 32'(doinit), 32'hFF);
    for (int s = 0; s < 12; s++) begin
      m_done = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_armed[c] && intr_pat[s][c]) begin
          if (m_cnt[c] == EPW'(1)) begin
            m_armed[c] = 1'b0;
            m_done[c]  = 1'b1;
          end else begin
            m_cnt[c] = m_cnt[c] - EPW'(1);
          end
        end
      end
      pulse_intr(intr_pat[s]);
      check_eq($sformatf("t5_doinit_s%0d", s), 32'(doinit), 32'(m_armed));
      check_eq($sformatf("t5_done_s%0d", s), 32'(done_pulse), 32'(m_done));
    end
    check_eq("t5_all_idle", 32'(doinit), 32'h00);

    // ---- asynchronous reset mid-operation ----
    arm(8'hFF, 4'd5, 1'b1, 16'd100);
    check_eq("t6_armed", 32'(doinit), 32'hFF);
    check_eq("t6_busy", 32'(busy), 32'h1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_doinit", 32'(doinit), 32'h00);
    check_eq("t6_rst_busy", 32'(busy), 32'h0);
    check_eq("t6_rst_done", 32'(done_pulse), 32'h00);
    #2 reset_n = 1'b1;
    done_seen = '0;
    for (int s = 0; s < 6; s++) begin
      pulse_intr(8'hFF);
      done_seen |= done_pulse;
    end
    check_eq("t6_no_done_after", 32'(done_seen), 32'h00);
    check_eq("t6_doinit_after", 32'(doinit), 32'h00);
    check_eq("t6_tflag_after", 32'(timeout_flag), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/channel_doinit_bank.md
Name: channel_doinit_bank

Overview:
- Multi-channel successor to the single-bit doinit flag in the correlator block of the imitator.
- Holds one doinit flag per correlator channel. A flag is set by a software write pulse and cleared after a programmable number of channel interrupt (epoch) pulses.
- An optional watchdog per channel force-clears a flag that never sees its interrupts and records a sticky timeout.
- Sits between the register file (write/clear pulses) and the correlator channels (doinit consumers, intr_pulse sources).

Parameters:
- NUM_CH, 8, number of correlator channels.
- EPW, 4, width of the hold-epoch count.
- TOW, 16, width of the watchdog cycle count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- doinit_pulse  in  NUM_CH  per-channel one-cycle set request from a register write.
- intr_pulse  in  NUM_CH  per-channel epoch/interrupt pulse from the channel.
- hold_epochs  in  EPW  number of intr pulses the flag must survive; sampled on set; 0 is treated as 1.
- timeout_en  in  1  watchdog enable; sampled per channel on set.
- timeout_cycles  in  TOW  watchdog load value; sampled on set.
- sts_clr  in  NUM_CH  per-channel clear of the sticky timeout flag.
- doinit  out  NUM_CH  per-channel doinit flag.
- done_pulse  out  NUM_CH  one-cycle pulse on normal (interrupt) completion.
- timeout_flag  out  NUM_CH  sticky watchdog-expiry flag.
- busy  out  1  OR-reduction of doinit, registered.

Behaviour:
- Reset: all outputs 0, all counters 0, every channel IDLE. Reset is asynchronous; asserting it mid-operation aborts any armed channel with no done_pulse.
- Channels are fully independent. Each channel is a 2-state FSM: IDLE (doinit=0) and ARMED (doinit=1).
- Set:
  - doinit_pulse[i]=1 at edge k gives doinit[i]=1 from cycle k+1.
  - Epoch counter loads max(hold_epochs,1); watchdog counter loads timeout_cycles; the channel's wd_en bit loads timeout_en.
- Re-set while ARMED: reloads both counters and wd_en, keeps doinit=1, no done_pulse (restart semantics).
- Epoch count (ARMED, no doinit_pulse):
  - Each intr_pulse[i] decrements the epoch counter.
  - intr_pulse with counter==1 is the completing edge: the next cycle has doinit[i]=0 and done_pulse[i]=1 for exactly one cycle, and the FSM returns to IDLE.
  - intr_pulse while IDLE is ignored.
- Watchdog (ARMED, wd_en=1, no doinit_pulse, no completing intr):
  - If counter==0: expiry. The next cycle has doinit[i]=0 and timeout_flag[i]=1; no done_pulse; FSM returns to IDLE.
  - Otherwise the counter decrements.
  - With no intr, doinit stays high for timeout_cycles+1 cycles; timeout_cycles=0 gives exactly 1 cycle.
- wd_en=0: the watchdog counter is frozen and no expiry occurs.
- Priority within one cycle per channel: doinit_pulse > completing intr_pulse > watchdog expiry. Completion and expiry in the same cycle yield done_pulse with no timeout_flag.
- timeout_flag: cleared by sts_clr[i] one cycle later. Expiry in the same cycle as sts_clr sets the flag (set wins). Not cleared by a new doinit_pulse.
- busy = registered OR of the next-state doinit vector, so it is cycle-aligned with doinit.
- Counters never wrap: the epoch counter stops at 1 and leaves only via completion or re-set; the watchdog counter stops at 0 via expiry.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package (correlator_pkg):
  - Channel FSM enumeration: IDLE, ARMED.
  - Default constants: NUM_CH, EPW, TOW.
  - Helper constant for the "0 treated as 1" epoch load.
- One sub-module: channel_doinit_slice. It holds one channel's FSM, epoch counter, watchdog counter, wd_en, done_pulse and sticky flag, and is generated NUM_CH times.
- The bank top contains only the generate loop and the busy register.

Test Plan:
- Basic hold=1: reset; doinit_pulse[0] at cycle 10, hold_epochs=1, timeout_en=0; intr_pulse[0] at cycle 20 -> doinit[0] high cycles 11..20, low from 21; done_pulse[0] high only in cycle 21; busy tracks doinit[0].
- Multi-epoch with ignored idle intr: hold_epochs=3 on channel 2, intr_pulse[2] at cycles 5 (IDLE), 15, 25, 35, set at cycle 10 -> cycle-5 pulse ignored; doinit[2] clears after the cycle-35 pulse; exactly one done_pulse; hold_epochs=0 behaves as 1.
- Watchdog: timeout_en=1, timeout_cycles=4, set at cycle 10, no intr -> doinit high 5 cycles (11..15), low at 16; timeout_flag=1 from 16; no done_pulse. sts_clr at 20 -> flag low from 21.
- Collisions:
  - doinit_pulse and completing intr_pulse same cycle -> stays ARMED, counters reloaded, no done_pulse.
  - Completing intr on the expiry cycle -> done_pulse=1, timeout_flag=0.
  - sts_clr on the expiry cycle -> flag=1.
- Independence and mid-op reset: arm all 8 channels with different holds and interleaved intr -> each clears on its own count. Assert reset_n asynchronously mid-sequence -> all outputs 0 immediately, no done_pulse after release.
